// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter: round-robin arbiter sharing the single async-FIFO write port.
// A grant is held for one packet (capped at MAX_BURST beats) and throttled by wfull.
module fifo_wr_arbiter #(
  parameter int NREQ      = 4,
  parameter int DSIZE     = 8,
  parameter int MAX_BURST = 8,
  parameter int GW        = $clog2(NREQ)
) (
  input  logic [0:0]            wclk,
  input  logic                  wrst_n,
  input  logic [NREQ-1:0]       req_valid,
  input  logic [NREQ-1:0]       req_last,
  input  logic [NREQ*DSIZE-1:0] req_data,
  output logic [NREQ-1:0]       req_ready,
  input  logic                  wfull,
  output logic                  winc,
  output logic [DSIZE-1:0]      wdata,
  output logic [GW-1:0]         grant_id,
  output logic                  busy
);
  localparam int CW = $clog2(MAX_BURST + 1);

  typedef enum logic {IDLE, BURST} state_t;

  state_t          state_reg, state_next;
  logic [GW-1:0]   grant_reg, grant_next;
  logic [GW-1:0]   last_reg, last_next;
  logic [CW-1:0]   cnt_reg, cnt_next;
  logic [GW-1:0]   pick;
  logic            found;
  int              idx;
  logic [DSIZE-1:0] data_arr [NREQ];

  for (genvar gi = 0; gi < NREQ; gi++) begin : g_slice
    assign data_arr[gi] = req_data[gi*DSIZE +: DSIZE];
  end

  // Search starts one past the previous winner, so that winner has lowest priority.
  always_comb begin
    pick  = last_reg;
    found = 1'b0;
    idx   = 0;
    for (int k = 1; k <= NREQ; k++) begin
      idx = (int'(last_reg) + k) % NREQ;
      if (!found && req_valid[GW'(idx)]) begin
        pick  = GW'(idx);
        found = 1'b1;
      end
    end
  end

  always_comb begin
    state_next = state_reg;
    grant_next = grant_reg;
    last_next  = last_reg;
    cnt_next   = cnt_reg;
    req_ready  = '0;
    winc       = 1'b0;
    wdata      = '0;
    case (state_reg)
      IDLE: begin
        if (found) begin
          grant_next = pick;
          last_next  = pick;
          cnt_next   = '0;
          state_next = BURST;
        end
      end
      BURST: begin
        req_ready[grant_reg] = ~wfull;
        winc  = req_valid[grant_reg] & ~wfull;
        wdata = data_arr[grant_reg];
        if (winc) begin
          cnt_next = cnt_reg + CW'(1);
          if (req_last[grant_reg] || (cnt_reg == CW'(MAX_BURST - 1))) begin
            state_next = IDLE;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge wclk) begin
    if (!wrst_n) begin
      state_reg <= IDLE;
      grant_reg <= '0;
      last_reg  <= GW'(NREQ - 1);
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      grant_reg <= grant_next;
      last_reg  <= last_next;
      cnt_reg   <= cnt_next;
    end
  end

  assign busy     = (state_reg == BURST);
  assign grant_id = grant_reg;

endmodule
